// File: rtl/uart_reg_ctrl.sv
// Byte-protocol register controller: decodes command bytes from the RX FIFO,
// drives the control/sample registers and returns register reads via the TX FIFO.
module uart_reg_ctrl #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  output logic        rx_rd,
  output logic [7:0]  tx_data,
  input  logic        tx_full,
  output logic        tx_wr,
  output logic [2:0]  cr,
  input  logic [7:0]  sr,
  output logic [10:0] din,
  output logic        din_vld,
  input  logic [20:0] dout,
  output logic        proto_err
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state_r;
  logic [2:0]    cmd_addr_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    cr_r;
  logic [7:0]    dinl_r;
  logic [2:0]    dinh_r;
  logic          din_vld_r;
  logic [7:0]    tx_data_r;
  logic          proto_err_r;
  logic [20:0]   shadow_r;
  logic [7:0]    rd_val_s;

  // Read mux keyed by the address of the command byte currently at the RX head
  always_comb begin
    rd_val_s = 8'h00;
    case (rx_data[2:0])
      3'd0:    rd_val_s = {5'b00000, cr_r};
      3'd1:    rd_val_s = sr;
      3'd2:    rd_val_s = dinl_r;
      3'd3:    rd_val_s = {5'b00000, dinh_r};
      3'd4:    rd_val_s = dout[7:0];
      3'd5:    rd_val_s = shadow_r[15:8];
      3'd6:    rd_val_s = {3'b000, shadow_r[20:16]};
      default: rd_val_s = 8'h00;
    endcase
  end

  // FIFO strobes stay combinational; the state encoding keeps them mutually exclusive
  always_comb begin
    if (rst) begin
      rx_rd = 1'b0;
      tx_wr = 1'b0;
    end else begin
      rx_rd = ((state_r == IDLE) || (state_r == WDATA)) && !rx_empty;
      tx_wr = (state_r == RESP) && !tx_full;
    end
  end

  // Command FSM, register file, read shadow and strobe generation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cmd_addr_r  <= 3'd0;
      cnt_r       <= '0;
      cr_r        <= 3'd0;
      dinl_r      <= 8'h00;
      dinh_r      <= 3'd0;
      din_vld_r   <= 1'b0;
      tx_data_r   <= 8'h00;
      proto_err_r <= 1'b0;
      shadow_r    <= 21'd0;
    end else begin
      din_vld_r   <= 1'b0;
      proto_err_r <= 1'b0;
      cr_r[2]     <= 1'b0;  // soft-reset bit of CR lives for one cycle only
      case (state_r)
        IDLE: begin
          if (!rx_empty) begin
            cmd_addr_r <= rx_data[2:0];
            if (rx_data[6:3] != 4'b0000) begin
              proto_err_r <= 1'b1;
            end else if (rx_data[7]) begin
              state_r <= WDATA;
              cnt_r   <= '0;
            end else begin
              tx_data_r <= rd_val_s;
              state_r   <= RESP;
              if (rx_data[2:0] == 3'd7) proto_err_r <= 1'b1;
              if (rx_data[2:0] == 3'd4) shadow_r <= dout;
            end
          end
        end
        WDATA: begin
          // a byte arriving on the last counter value still wins over the timeout
          if (!rx_empty) begin
            state_r <= IDLE;
            case (cmd_addr_r)
              3'd0: cr_r <= rx_data[2:0];
              3'd2: dinl_r <= rx_data;
              3'd3: begin
                dinh_r    <= rx_data[2:0];
                din_vld_r <= 1'b1;
              end
              default: proto_err_r <= 1'b1;
            endcase
          end else if (cnt_r == CNT_LAST) begin
            proto_err_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        RESP: begin
          if (!tx_full) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign tx_data   = tx_data_r;
  assign cr        = cr_r;
  assign din       = {dinh_r, dinl_r};
  assign din_vld   = din_vld_r;
  assign proto_err = proto_err_r;

endmodule
